// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
// The entry dest field is sized for the widest supported register address (REG_AW <= DEST_W_MAX).
package id_hazard_scoreboard_pkg;

  localparam int REG_AW_DEF     = 4;
  localparam int PIPE_DEPTH_DEF = 2;
  localparam int DEST_W_MAX     = 8;
  localparam int FWD_SEL_RF     = 0;

  typedef struct packed {
    logic                  valid;
    logic [DEST_W_MAX-1:0] dest;
    logic                  is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// ID-stage to hazard-unit signal bundle; master is the ID stage, slave is the hazard unit.
interface id_hazard_scoreboard_if
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
);

  logic              id_valid;
  logic              id_wb_en;
  logic              id_mem_r;
  logic [REG_AW-1:0] id_dest;
  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  logic              two_src;
  logic              forward_en;
  logic              flush;
  logic              mem_freeze;
  logic              hazard_detected;
  logic [SEL_W-1:0]  fwd_sel1;
  logic [SEL_W-1:0]  fwd_sel2;

  modport master (
    output id_valid, id_wb_en, id_mem_r, id_dest, src1, src2, two_src,
           forward_en, flush, mem_freeze,
    input  hazard_detected, fwd_sel1, fwd_sel2
  );

  modport slave (
    input  id_valid, id_wb_en, id_mem_r, id_dest, src1, src2, two_src,
           forward_en, flush, mem_freeze,
    output hazard_detected, fwd_sel1, fwd_sel2
  );

endinterface

// File: rtl/id_hazard_scoreboard_src_match.sv
// Per-operand lookup: finds the youngest (lowest-index) valid scoreboard entry writing src_i.
module hazard_src_match
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  sb_entry_t [PIPE_DEPTH-1:0] sb_i,
  input  logic [DEST_W_MAX-1:0]      src_i,
  input  logic                       en_i,
  output logic                       hit_o,
  output logic [SEL_W-1:0]           idx_o,
  output logic                       is_load_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    hit_o     = 1'b0;
    idx_o     = '0;
    is_load_o = 1'b0;
    // Oldest to youngest: the last hit assigned is the youngest producer.
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      if (en_i && sb_i[k].valid && (sb_i[k].dest == src_i)) begin
        hit_o     = 1'b1;
        idx_o     = SEL_W'(k);
        is_load_o = sb_i[k].is_load;
      end
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard unit: in-flight write scoreboard, stall request and forwarding selects.
// Optional HAZARD_STATS_EN adds saturating stall_cycles / load_use_events counters.
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  id_hazard_scoreboard_if.slave  bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            load_use_events
`endif
);

  sb_entry_t [PIPE_DEPTH-1:0] sb_q, sb_d;

  logic             hit1, hit2, ld1, ld2;
  logic [SEL_W-1:0] idx1, idx2;
  logic             load_use, hazard;

  hazard_src_match #(.PIPE_DEPTH(PIPE_DEPTH), .SEL_W(SEL_W)) u_match1 (
    .sb_i      (sb_q),
    .src_i     (DEST_W_MAX'(bus.src1)),
    .en_i      (1'b1),
    .hit_o     (hit1),
    .idx_o     (idx1),
    .is_load_o (ld1)
  );

  hazard_src_match #(.PIPE_DEPTH(PIPE_DEPTH), .SEL_W(SEL_W)) u_match2 (
    .sb_i      (sb_q),
    .src_i     (DEST_W_MAX'(bus.src2)),
    .en_i      (bus.two_src),
    .hit_o     (hit2),
    .idx_o     (idx2),
    .is_load_o (ld2)
  );

  // Load-use: the youngest producer is a load still in EXE, its data is not yet forwardable.
  assign load_use = bus.forward_en &&
                    ((hit1 && (idx1 == '0) && ld1) || (hit2 && (idx2 == '0) && ld2));

  assign hazard = bus.mem_freeze || (bus.forward_en ? load_use : (hit1 || hit2));

  assign bus.hazard_detected = hazard;
  assign bus.fwd_sel1 = (!bus.forward_en || hazard || !hit1) ? SEL_W'(FWD_SEL_RF) : idx1 + SEL_W'(1);
  assign bus.fwd_sel2 = (!bus.forward_en || hazard || !hit2) ? SEL_W'(FWD_SEL_RF) : idx2 + SEL_W'(1);

  always_comb begin
    sb_d = sb_q;
    if (!bus.mem_freeze) begin
      for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
        sb_d[k] = sb_q[k-1];
      end
      if (bus.flush || hazard || !(bus.id_valid && bus.id_wb_en)) begin
        sb_d[0] = SB_BUBBLE;
      end else begin
        sb_d[0] = '{valid: 1'b1, dest: DEST_W_MAX'(bus.id_dest), is_load: bus.id_mem_r};
      end
    end
  end

  // NOTE: the scoreboard is a few flops, not a RAM, so it is reset whole; only valid matters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      // NOTE: non-blocking assignment so every register samples pre-edge values.
      sb_q <= sb_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, load_use_events_q;
  logic        load_use_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q    <= '0;
      load_use_events_q <= '0;
      load_use_q        <= 1'b0;
    end else begin
      load_use_q <= load_use;
      if (hazard && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (load_use && !load_use_q && (load_use_events_q != '1)) begin
        load_use_events_q <= load_use_events_q + 32'd1;
      end
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign load_use_events = load_use_events_q;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard (PIPE_DEPTH=2): expectations queued, monitor compares.
module tb_id_hazard_scoreboard;

  localparam int REG_AW     = 4;
  localparam int PIPE_DEPTH = 2;
  localparam int SEL_W      = $clog2(PIPE_DEPTH + 1);

  typedef struct {
    string            name;
    logic             haz;
    logic [SEL_W-1:0] sel1;
    logic [SEL_W-1:0] sel2;
    bit               cnt_chk;
    logic [31:0]      stalls;
    logic [31:0]      lu_events;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  event mon_ev;

  id_hazard_scoreboard_if #(.REG_AW(REG_AW), .PIPE_DEPTH(PIPE_DEPTH)) bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, load_use_events;
`endif

  id_hazard_scoreboard #(.REG_AW(REG_AW), .PIPE_DEPTH(PIPE_DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus.slave)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles    (stall_cycles),
    .load_use_events (load_use_events)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares whatever expectations are pending when outputs are sampled.
  initial begin
    forever begin
      @(negedge clk or mon_ev);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".haz"},  32'(bus.hazard_detected), 32'(e.haz));
        check({e.name, ".sel1"}, 32'(bus.fwd_sel1),        32'(e.sel1));
        check({e.name, ".sel2"}, 32'(bus.fwd_sel2),        32'(e.sel2));
`ifdef HAZARD_STATS_EN
        if (e.cnt_chk) begin
          check({e.name, ".stall_cycles"},    stall_cycles,    e.stalls);
          check({e.name, ".load_use_events"}, load_use_events, e.lu_events);
        end
`endif
      end
    end
  end

  task automatic id_in(input logic v, input logic wb, input logic mr, input logic [3:0] d,
                       input logic [3:0] a, input logic [3:0] b, input logic two);
    bus.id_valid = v;
    bus.id_wb_en = wb;
    bus.id_mem_r = mr;
    bus.id_dest  = d;
    bus.src1     = a;
    bus.src2     = b;
    bus.two_src  = two;
  endtask

  task automatic push(input string nm, input logic h, input logic [SEL_W-1:0] s1,
                      input logic [SEL_W-1:0] s2, input bit cc, input logic [31:0] sc,
                      input logic [31:0] lu);
    exp_t e;
    e = '{name: nm, haz: h, sel1: s1, sel2: s2, cnt_chk: cc, stalls: sc, lu_events: lu};
    exp_q.push_back(e);
  endtask

  // One cycle: expectation for the current inputs, then advance to just after the next edge.
  task automatic step(input string nm, input logic h, input logic [SEL_W-1:0] s1,
                      input logic [SEL_W-1:0] s2);
    push(nm, h, s1, s2, 1'b0, '0, '0);
    @(posedge clk);
    #1;
  endtask

  task automatic step_cnt(input string nm, input logic h, input logic [SEL_W-1:0] s1,
                          input logic [SEL_W-1:0] s2, input logic [31:0] sc, input logic [31:0] lu);
    push(nm, h, s1, s2, 1'b1, sc, lu);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.forward_en = 1'b0;
    bus.flush      = 1'b0;
    bus.mem_freeze = 1'b0;
    id_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step_cnt("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("idle", 0, 0, 0);

    // No forwarding: consumer waits until the producer retires.
    id_in(1, 1, 0, 3, 0, 0, 0);  step("a_issue_r3", 0, 0, 0);
    id_in(1, 0, 0, 0, 3, 0, 0);  step("a_stall0", 1, 0, 0);
                                 step("a_stall1", 1, 0, 0);
                                 step("a_release", 0, 0, 0);
    id_in(1, 1, 0, 8, 0, 0, 0);  step("a2_issue_r8", 0, 0, 0);
    id_in(1, 0, 0, 0, 0, 8, 0);  step("a2_src2_dead", 0, 0, 0);
    id_in(1, 0, 0, 0, 0, 8, 1);  step("a2_src2_live", 1, 0, 0);

    // Forwarding: load-use stalls one cycle, then forwards from entry 1.
    bus.forward_en = 1'b1;
    id_in(1, 1, 1, 5, 0, 0, 0);  step("b_load_r5", 0, 0, 0);
    id_in(1, 0, 0, 0, 0, 5, 1);  step("b_load_use", 1, 0, 0);
                                 step("b_fwd_e1", 0, 0, 2);
    id_in(1, 1, 0, 7, 0, 0, 0);  step("c_alu_r7", 0, 0, 0);
    id_in(1, 0, 0, 0, 7, 7, 0);  step("c_fwd_e0", 0, 1, 0);
    id_in(1, 0, 0, 0, 7, 7, 1);  step("c_fwd_e1", 0, 2, 2);

    // Youngest producer wins: ALU r4 then load r4.
    id_in(1, 1, 0, 4, 0, 0, 0);  step("y_alu_r4", 0, 0, 0);
    id_in(1, 1, 1, 4, 4, 0, 0);  step("y_fwd_e0", 0, 1, 0);
    id_in(1, 0, 0, 0, 4, 0, 0);  step("y_youngest_load", 1, 0, 0);
                                 step("y_after", 0, 2, 0);

    // Flush kills only the incoming write.
    bus.forward_en = 1'b0;
    bus.flush = 1'b1;  id_in(1, 1, 0, 2, 0, 0, 0);  step("d_flush_w2", 0, 0, 0);
    bus.flush = 1'b0;  id_in(1, 0, 0, 0, 2, 0, 0);  step("d_no_hazard", 0, 0, 0);
    bus.forward_en = 1'b1;
    id_in(1, 1, 0, 6, 0, 0, 0);                     step("d_w6", 0, 0, 0);
    bus.flush = 1'b1;  id_in(1, 1, 0, 6, 6, 0, 0);  step("d_flush_fwd", 0, 1, 0);
    bus.flush = 1'b0;  id_in(1, 0, 0, 0, 6, 0, 0);  step("d_older_kept", 0, 2, 0);

    // Memory freeze: stall held, scoreboard frozen, frozen ID write never enters.
    id_in(1, 1, 0, 9, 0, 0, 0);  step("e_w9", 0, 0, 0);
    bus.mem_freeze = 1'b1;
    id_in(1, 1, 0, 1, 9, 0, 0);
    for (int i = 0; i < 3; i++) step($sformatf("e_freeze%0d", i), 1, 0, 0);
    bus.mem_freeze = 1'b0;
    id_in(1, 0, 0, 0, 9, 1, 1);  step("e_thaw", 0, 1, 0);
                                 step("e_aged", 0, 2, 0);

    // Counter section starts from a fresh asynchronous reset.
    rst = 1'b1;
    #1;
    push("s_rst_pulse", 0, 0, 0, 1'b1, 0, 0);
    ->mon_ev;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      logic [3:0] r;
      r = 4'(10 + i);
      id_in(1, 1, 1, r, 0, 0, 0);  step($sformatf("s_load%0d", i), 0, 0, 0);
      id_in(1, 0, 0, 0, r, 0, 0);  step($sformatf("s_use%0d", i), 1, 0, 0);
                                   step($sformatf("s_fwd%0d", i), 0, 2, 0);
    end
    id_in(0, 0, 0, 0, 0, 0, 0);  step_cnt("s_counts", 0, 0, 0, 3, 3);

    // Reset asserted in the middle of a load-use stall.
    id_in(1, 1, 1, 5, 0, 0, 0);  step("s_load4", 0, 0, 0);
    id_in(1, 0, 0, 0, 5, 0, 0);
    push("s_stall4", 1, 0, 0, 1'b1, 3, 3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    push("s_rst_mid", 0, 0, 0, 1'b1, 0, 0);
    ->mon_ev;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step_cnt("s_after_rst", 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_hazard_scoreboard.md
# id_hazard_scoreboard

Parametrised ID-stage hazard unit. It tracks every in-flight register write in a shift-register scoreboard, PIPE_DEPTH entries deep, between ID and WB. It produces the stall request, the per-operand forwarding selects and the load-use stall. It handles flush, memory freeze and configurable pipeline depth, and sits between the ID stage and the ID/EXE pipeline register.

## Interface
- REG_AW, 4: register address width.
- PIPE_DEPTH, 2: tracked stages after ID (entry 0 = EXE, PIPE_DEPTH-1 = last stage before WB commit); range 1..6.
- SEL_W, $clog2(PIPE_DEPTH+1): forwarding select width.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_wb_en  in  1  ID instruction writes a register.
- id_mem_r  in  1  ID instruction is a load.
- id_dest  in  REG_AW  ID destination.
- src1, src2  in  REG_AW  ID source registers.
- two_src  in  1  src2 is live.
- forward_en  in  1  forwarding network enabled.
- flush  in  1  branch taken; kill ID and entry 0.
- mem_freeze  in  1  memory stage busy; whole pipe frozen.
- hazard_detected  out  1  stall ID/IF this cycle.
- fwd_sel1, fwd_sel2  out  SEL_W  0 = register file, k = value from entry k-1.

## Operation
- Entry fields: valid, dest, is_load. Matching applies only to valid entries with equal dest. src2 matches only when two_src=1.
- Youngest match: the lowest-index matching entry wins for each operand.
- forward_en=0: hazard_detected=1 on any match on either live operand. fwd_sel=0.
- forward_en=1:
  - hazard_detected=1 only when the youngest match is entry 0 with is_load=1 (load-use).
  - Otherwise fwd_sel = youngest match index+1, or 0 when there is no match.
  - During a hazard, fwd_sel is forced to 0.
- mem_freeze=1 forces hazard_detected=1, and the scoreboard holds.
- Update priority, highest first:
  1. rst: all valid=0.
  2. mem_freeze: hold.
  3. Otherwise, shift entry k to k+1, and the last entry retires. Entry 0 is then loaded as follows:
     - If flush, or hazard_detected, or !(id_valid && id_wb_en): load a bubble (valid=0).
     - Else load {1, id_dest, id_mem_r}.
- flush also clears the incoming entry-0 write only. Older entries are past the branch and are kept.
- Matching on dest is width-exact. No register is treated specially.

## Timing
- hazard_detected and fwd_sel are combinational from the inputs and the registered scoreboard, valid in the same cycle. Latency 0.
- Scoreboard latency: an ID instruction becomes visible as entry 0 on the next edge and retires after PIPE_DEPTH edges.
- Reset values: all entries invalid. With mem_freeze=0, outputs read hazard_detected=0 and fwd_sel=0.
- Reset asserted mid-stall clears all entries immediately and asynchronously. The stall drops in the same cycle unless mem_freeze=1.
- A load-use stall lasts exactly 1 cycle with forwarding on. A bubble enters entry 0, and the load moves to entry 1.
- Without forwarding, a dependency stalls until the producer retires, at most PIPE_DEPTH cycles.
- flush and hazard in the same cycle: a bubble enters. No double counting.

## Configuration
- HAZARD_STATS_EN defined: adds outputs stall_cycles and load_use_events, each 32 bits. They are counters cleared by rst.
  - stall_cycles increments on every cycle with hazard_detected=1.
  - load_use_events increments on each rising edge of a load-use stall.
  - Both saturate at all-ones.
- Not defined: no counters and no extra ports. Behaviour is otherwise identical.

## Structure
- Shared package/header holds:
  - the entry typedef {valid, dest, is_load};
  - default REG_AW and PIPE_DEPTH;
  - the FWD_SEL_RF=0 constant.
- Sub-module hazard_src_match, instantiated once per operand. It takes the scoreboard vector, src and enable, and returns hit, youngest index and is_load of the hit.

## Test plan
- Reset, then idle: hazard_detected=0, fwd_sel1=fwd_sel2=0.
- forward_en=0. Issue write r3, then next cycle src1=r3: hazard=1 for 2 cycles (PIPE_DEPTH=2), then 0.
- forward_en=1. Load r5, then next cycle src2=r5 with two_src=1: hazard=1 for 1 cycle. The cycle after, fwd_sel2=2.
- forward_en=1. ALU write r7, then src1=r7: no stall and fwd_sel1=1. With two_src=0 and src2=r7: fwd_sel2=0.
- flush with ID writing r2, then src1=r2: no hazard. Likewise, mem_freeze held 3 cycles keeps hazard=1 and freezes the entries.
- HAZARD_STATS_EN: three separate load-use stalls give load_use_events=3 and stall_cycles=3. Assert rst mid-stall: counters read 0 and hazard drops immediately.
